// File: rtl/weyl_stream_decoder.sv
// rtl/weyl_stream_decoder.sv - recovers the quota from a Weyl-permuted unary bitstream and flags malformed frames
module weyl_stream_decoder #(
    parameter int BITSTREAM = 64,
    parameter int BASE      = 61,
    parameter int STRIDE    = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic                         in_bit,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(BITSTREAM):0]   quota_num,
    output logic                         quota_err
);
    localparam int PW = $clog2(BITSTREAM);
    localparam int CW = PW + 1;

    function automatic int inv_mod(input int s, input int n);
        int r;
        r = 0;
        for (int x = 0; x < n; x++) begin
            if (((s * x) % n) == 1) r = x;
        end
        return r;
    endfunction

    localparam int INV_STRIDE = inv_mod(STRIDE % BITSTREAM, BITSTREAM);
    localparam int I0 = ((BITSTREAM - (BASE % BITSTREAM)) * INV_STRIDE) % BITSTREAM;
    localparam logic [PW-1:0] INV_P = PW'(INV_STRIDE);
    localparam logic [PW-1:0] I0_P  = PW'(I0);
    localparam logic [PW-1:0] LAST_POS = PW'(BITSTREAM - 1);

    if (STRIDE % 2 == 0) begin : g_stride_check
        $error("weyl_stream_decoder: STRIDE must be odd");
    end

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t          state;
    logic [PW-1:0]   pos;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   max_idx;
    logic [CW-1:0]   count;

    logic [CW-1:0]   count_nxt;
    logic [PW-1:0]   max_nxt;
    logic            err_nxt;

    // in_ready must drop in the same cycle abort is raised, so it cannot be registered
    assign in_ready = (state == COLLECT) && !abort;

    always_comb begin
        count_nxt = count + CW'(in_bit);
        max_nxt   = max_idx;
        if (in_bit && (idx > max_idx)) max_nxt = idx;
        // distinct indices with max == count-1 means they are exactly 0..count-1
        err_nxt   = (count_nxt != '0) && (({1'b0, max_nxt} + CW'(1)) != count_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            pos       <= '0;
            idx       <= I0_P;
            count     <= '0;
            max_idx   <= '0;
            out_valid <= 1'b0;
            quota_num <= '0;
            quota_err <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (abort) begin
                        pos     <= '0;
                        idx     <= I0_P;
                        count   <= '0;
                        max_idx <= '0;
                    end else if (in_valid) begin
                        pos     <= pos + PW'(1);
                        idx     <= idx + INV_P;
                        count   <= count_nxt;
                        max_idx <= max_nxt;
                        if (pos == LAST_POS) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            quota_num <= count_nxt;
                            quota_err <= err_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        pos       <= '0;
                        idx       <= I0_P;
                        count     <= '0;
                        max_idx   <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: doc/weyl_stream_decoder.md
Name: weyl_stream_decoder

Overview:
- Receive end of the Weyl-permuted unary bitstream produced by the quota-to-bitstream mapper.
- Accepts one stream bit per handshake, in position order 0..BITSTREAM-1, and recovers the quota value, i.e. the count of ones.
- Checks that the ones occupy exactly the Weyl prefix positions, i.e. permutation indices 0..count-1.
- Presents the decoded quota and an error flag on a ready/valid output.

Parameters:
- BITSTREAM, 64, stream length per frame; power of two, >= 4.
- BASE, 61, Weyl phase offset; must match the transmitting mapper.
- STRIDE, 17, Weyl stride; must be odd (coprime with BITSTREAM); must match the transmitting mapper.
- Derived localparams, computed at elaboration:
  - INV_STRIDE = STRIDE^-1 mod BITSTREAM (49 for defaults).
  - I0 = ((BITSTREAM-BASE)*INV_STRIDE) mod BITSTREAM (19 for defaults).
- Elaboration fails if STRIDE is even.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous frame discard.
- in_valid  in  1  stream bit valid.
- in_bit  in  1  stream bit at current position.
- in_ready  out  1  decoder accepts a bit this cycle.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts result.
- quota_num  out  $clog2(BITSTREAM)+1  decoded count of ones, 0..BITSTREAM.
- quota_err  out  1  stream is not a valid Weyl prefix pattern.

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT; pos=0; idx=I0; count=0; max_idx=0.
  - out_valid=0, quota_num=0, quota_err=0, in_ready=1.
- Registers:
  - pos: $clog2(BITSTREAM) bits.
  - idx: permutation index of the current position, $clog2(BITSTREAM) bits.
  - count: $clog2(BITSTREAM)+1 bits.
  - max_idx: largest idx seen carrying a 1.
- COLLECT state: in_ready=1, out_valid=0.
  - Accept occurs when in_valid=1.
  - On accept:
    - pos+1.
    - idx = (idx+INV_STRIDE) mod BITSTREAM, wrapping naturally at the register width.
    - If in_bit=1: count+1, and max_idx=max(max_idx, idx_current).
  - Accept at pos=BITSTREAM-1 → next cycle state=HOLD, out_valid=1, quota_num=final count (including this bit).
  - quota_err in that case = (final count != 0) && (final max_idx+1 != final count).
- HOLD state: in_ready=0.
  - out_valid, quota_num and quota_err stay stable until out_ready=1.
  - Handshake cycle (out_valid&&out_ready):
    - Next cycle out_valid=0, state=COLLECT.
    - pos=0, idx=I0, count=0, max_idx=0.
    - quota_num and quota_err retain their last value.
- Latency: out_valid rises 1 cycle after the last bit is accepted. Throughput is one frame per BITSTREAM+1 cycles with out_ready tied high.
- The decoder never accepts input while in HOLD. in_bit is ignored when in_valid=0.
- abort=1:
  - In COLLECT: clears pos, idx, count and max_idx to reset values; any bit presented in that cycle is not accepted; in_ready is forced 0 that cycle.
  - In HOLD: no effect; the result is still delivered.
- Async reset mid-frame or mid-HOLD discards all state immediately.
- count=BITSTREAM (all ones) is a legal result, with quota_err=0.

Test Plan:
- Reset, then 64 zero bits → out_valid 1 cycle after the 64th accept; quota_num=0, quota_err=0.
- Ones at positions 1,14,31,48,61 only → quota_num=5, quota_err=0.
- All ones except position 44 → quota_num=63, quota_err=0.
- All 64 ones → quota_num=64, quota_err=0.
- Single one at position 0 (idx 19) → quota_num=1, quota_err=1.
- Handshake and control stress:
  - Random in_valid gaps plus out_ready low for 3 cycles → result held stable, in_ready=0 throughout HOLD.
  - Back-to-back frames decode correctly.
  - abort at pos 20 followed by a clean 5-quota frame → quota_num=5.
  - rst_n pulse at pos 30 → all outputs return to reset values.
